// File: rtl/sha256_pkg.sv
// Shared SHA-256 types, round constants and round functions for the compression core.
package sha256_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NUM_WORDS  = 8;
  localparam int unsigned NUM_ROUNDS = 64;
  localparam int unsigned IDX_W      = 6;

  typedef logic [WORD_W-1:0] word_t;
  // Element 7 maps to bits [255:224] (H0/A); element 0 to bits [31:0] (H7/H).
  typedef logic [NUM_WORDS-1:0][WORD_W-1:0] hash_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  localparam word_t K [NUM_ROUNDS] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic word_t rotr(input word_t x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  function automatic word_t big_sigma0(input word_t x);
    return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
  endfunction

  function automatic word_t big_sigma1(input word_t x);
    return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
  endfunction

  function automatic word_t maj(input word_t a, input word_t b, input word_t c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_round_core_if.sv
// Control, message-word and result signals between a block producer and the round core.
interface sha256_round_core_if;
  import sha256_pkg::*;

  logic             start;
  hash_t            hash_in;
  logic             w_valid;
  word_t            w_data;
  logic             w_ready;
  logic             busy;
  logic             done;
  hash_t            hash_out;
  logic [IDX_W-1:0] round_idx;

  modport master (
    output start, hash_in, w_valid, w_data,
    input  w_ready, busy, done, hash_out, round_idx
  );

  modport slave (
    input  start, hash_in, w_valid, w_data,
    output w_ready, busy, done, hash_out, round_idx
  );
endinterface

// File: rtl/func_ch.sv
// SHA-256 choose function: each bit of e selects between f and g.
module func_ch
  import sha256_pkg::*;
(
  input  word_t e_i,
  input  word_t f_i,
  input  word_t g_i,
  output word_t ch_c_o
);
  assign ch_c_o = (e_i & f_i) ^ (~e_i & g_i);
endmodule

// File: rtl/sha256_round_core.sv
// SHA-256 compression of one block: one round per accepted W word, then a
// feed-forward add of the saved chaining value.
module sha256_round_core
  import sha256_pkg::*;
(
  input  logic clk,
  input  logic rst,
  sha256_round_core_if.slave bus
);

  state_e           state_q, state_d;
  hash_t            wv_q, wv_d;
  hash_t            hv_q, hv_d;
  hash_t            hash_q, hash_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             busy_q, w_ready_q;
  word_t            ch, t1, t2;

  // Working registers: A=wv[7], B=wv[6], ... H=wv[0].
  func_ch u_ch (
    .e_i    (wv_q[3]),
    .f_i    (wv_q[2]),
    .g_i    (wv_q[1]),
    .ch_c_o (ch)
  );

  always_comb t1 = wv_q[0] + big_sigma1(wv_q[3]) + ch + K[idx_q] + bus.w_data;
  always_comb t2 = big_sigma0(wv_q[7]) + maj(wv_q[7], wv_q[6], wv_q[5]);

  always_comb begin
    state_d = state_q;
    wv_d    = wv_q;
    hv_d    = hv_q;
    hash_d  = hash_q;
    idx_d   = idx_q;
    done_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          wv_d    = bus.hash_in;
          hv_d    = bus.hash_in;
          idx_d   = '0;
          state_d = ST_ROUND;
        end
      end
      ST_ROUND: begin
        if (bus.w_valid) begin
          wv_d  = {t1 + t2, wv_q[7], wv_q[6], wv_q[5],
                   wv_q[4] + t1, wv_q[3], wv_q[2], wv_q[1]};
          idx_d = idx_q + IDX_W'(1);
          if (idx_q == IDX_W'(NUM_ROUNDS - 1)) begin
            state_d = ST_FINAL;
          end
        end
      end
      ST_FINAL: begin
        for (int unsigned i = 0; i < NUM_WORDS; i++) begin
          hash_d[i] = hv_q[i] + wv_q[i];
        end
        done_d  = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wv_q      <= '0;
      hv_q      <= '0;
      hash_q    <= '0;
      idx_q     <= '0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
      w_ready_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wv_q      <= wv_d;
      hv_q      <= hv_d;
      hash_q    <= hash_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
      busy_q    <= (state_d != ST_IDLE);
      w_ready_q <= (state_d == ST_ROUND);
    end
  end

  assign bus.w_ready   = w_ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.hash_out  = hash_q;
  assign bus.round_idx = idx_q;

endmodule

// File: tb/tb_sha256_round_core.sv
// Bench for sha256_round_core: known-answer and random blocks against a
// word-level SHA-256 model, plus stall, abort, busy-start and back-to-back sequences.
module tb_sha256_round_core;

  logic clk = 1'b0;
  logic rst;

  sha256_round_core_if bus ();

  sha256_round_core dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [255:0] IV     = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_H  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPT_H = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [511:0] ABC_B  = {32'h61626380, 448'h0, 32'h00000018};
  localparam logic [511:0] EMPT_B = {32'h80000000, 480'h0};

  logic [31:0] tb_k [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  logic [31:0] sched [64];

  typedef struct {
    logic [255:0] hin;
    logic [511:0] blk;
    logic [255:0] exp;
    bit           use_model;
    int           nstall;
    int           poke_at;
  } vec_t;

  vec_t vecs [8];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] rr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] rand256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  function automatic logic [511:0] rand512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[32*i +: 32] = $urandom;
    return r;
  endfunction

  // Message schedule expansion of a 512-bit block into W[0..63].
  task automatic build_sched(input logic [511:0] blk);
    logic [31:0] s0, s1;
    for (int t = 0; t < 64; t++) begin
      if (t < 16) begin
        sched[t] = blk[511 - 32*t -: 32];
      end else begin
        s0 = rr(sched[t-15], 7) ^ rr(sched[t-15], 18) ^ (sched[t-15] >> 3);
        s1 = rr(sched[t-2], 17) ^ rr(sched[t-2], 19) ^ (sched[t-2] >> 10);
        sched[t] = sched[t-16] + s0 + sched[t-7] + s1;
      end
    end
  endtask

  // Reference compression over the current schedule.
  function automatic logic [255:0] ref_compress(input logic [255:0] hin);
    logic [31:0] h [8];
    logic [31:0] v [8];
    logic [31:0] x1, x2, ch, mj, s0, s1;
    logic [255:0] r;
    for (int i = 0; i < 8; i++) begin
      h[i] = hin[255 - 32*i -: 32];
      v[i] = h[i];
    end
    for (int t = 0; t < 64; t++) begin
      s1 = rr(v[4], 6) ^ rr(v[4], 11) ^ rr(v[4], 25);
      ch = (v[4] & v[5]) ^ (~v[4] & v[6]);
      x1 = v[7] + s1 + ch + tb_k[t] + sched[t];
      s0 = rr(v[0], 2) ^ rr(v[0], 13) ^ rr(v[0], 22);
      mj = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      x2 = s0 + mj;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = v[4] + x1;
      v[0] = x1 + x2;
    end
    for (int i = 0; i < 8; i++) r[255 - 32*i -: 32] = h[i] + v[i];
    return r;
  endfunction

  // Drives one block; abort_at >= 0 resets the core when round t reaches it.
  task automatic run_block(input string name, input logic [255:0] hin, input logic [255:0] exp,
                           input int nstall, input int poke_at, input int abort_at);
    bit stall_at [64];
    int t, cyc, picked, idx_err, dcount;
    bit stalled, seen, poked, accepted, aborted;
    for (int i = 0; i < 64; i++) stall_at[i] = 1'b0;
    picked = 0;
    while (picked < nstall) begin
      int r;
      r = $urandom_range(0, 63);
      if (!stall_at[r]) begin
        stall_at[r] = 1'b1;
        picked++;
      end
    end
    bus.start   = 1'b1;
    bus.hash_in = hin;
    bus.w_valid = 1'b1;
    bus.w_data  = $urandom;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cyc = 1; t = 0; idx_err = 0;
    stalled = 0; seen = 0; poked = 0; aborted = 0;
    check({name, "_load"}, {bus.busy, bus.w_ready, bus.done}, 3'b110);
    while (cyc < 300 && !seen && !aborted) begin
      bus.start = 1'b0;
      if (bus.w_ready) begin
        if (int'(bus.round_idx) != t) idx_err++;
        if (t == poke_at && !poked) begin
          bus.start   = 1'b1;
          bus.hash_in = rand256();
          poked = 1;
        end
        if (stall_at[t] && !stalled) begin
          bus.w_valid = 1'b0;
          bus.w_data  = $urandom;
          stalled = 1;
        end else begin
          bus.w_valid = 1'b1;
          bus.w_data  = sched[t];
        end
      end else begin
        bus.w_valid = 1'($urandom_range(0, 1));
        bus.w_data  = $urandom;
      end
      if (t == abort_at && bus.w_ready) begin
        rst = 1'b1;
        aborted = 1;
      end
      accepted = bus.w_ready && bus.w_valid;
      @(posedge clk); #1;
      cyc++;
      if (accepted) begin
        t++;
        stalled = 0;
      end
      if (bus.done) seen = 1;
    end
    bus.start = 1'b0;
    if (aborted) begin
      rst = 1'b0;
      check({name, "_abort_busy"}, bus.busy, 1'b0);
      check({name, "_abort_hash"}, bus.hash_out, '0);
      check({name, "_abort_idx"}, bus.round_idx, 6'd0);
      check({name, "_abort_ready"}, bus.w_ready, 1'b0);
      dcount = int'(bus.done);
      for (int i = 0; i < 80; i++) begin
        bus.w_valid = 1'b1;
        bus.w_data  = $urandom;
        @(posedge clk); #1;
        if (bus.done) dcount++;
      end
      check({name, "_abort_no_done"}, dcount, 0);
    end else begin
      check({name, "_done_seen"}, seen, 1'b1);
      check({name, "_latency"}, cyc, 66 + nstall);
      check({name, "_hash"}, bus.hash_out, exp);
      check({name, "_idx_track"}, idx_err, 0);
      check({name, "_idx_wrap"}, bus.round_idx, 6'd0);
      check({name, "_busy_at_done"}, bus.busy, 1'b0);
    end
  endtask

  // After done, outputs must hold and done must drop.
  task automatic hold_check(input string name, input logic [255:0] exp);
    bus.start = 1'b0;
    @(posedge clk); #1;
    check({name, "_done_pulse"}, bus.done, 1'b0);
    repeat (3) begin
      bus.w_valid = 1'($urandom_range(0, 1));
      bus.w_data  = $urandom;
      @(posedge clk); #1;
    end
    check({name, "_hold"}, bus.hash_out, exp);
  endtask

  initial begin
    logic [255:0] h2;
    logic [511:0] b2;
    rst         = 1'b1;
    bus.start   = 1'b1;
    bus.hash_in = IV;
    bus.w_valid = 1'b1;
    bus.w_data  = 32'hdeadbeef;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", bus.busy, 1'b0);
    check("rst_done", bus.done, 1'b0);
    check("rst_ready", bus.w_ready, 1'b0);
    check("rst_idx", bus.round_idx, 6'd0);
    check("rst_hash", bus.hash_out, '0);
    rst       = 1'b0;
    bus.start = 1'b0;
    @(posedge clk); #1;
    check("idle_ignores_w", bus.busy, 1'b0);

    vecs[0] = '{hin: IV, blk: ABC_B,  exp: ABC_H,  use_model: 0, nstall: 0,  poke_at: -1};
    vecs[1] = '{hin: IV, blk: EMPT_B, exp: EMPT_H, use_model: 0, nstall: 0,  poke_at: -1};
    vecs[2] = '{hin: IV, blk: ABC_B,  exp: ABC_H,  use_model: 0, nstall: 10, poke_at: -1};
    vecs[3] = '{hin: IV, blk: ABC_B,  exp: ABC_H,  use_model: 0, nstall: 0,  poke_at: 10};
    for (int i = 4; i < 8; i++) begin
      vecs[i] = '{hin: rand256(), blk: rand512(), exp: '0, use_model: 1,
                  nstall: int'($urandom_range(0, 4)), poke_at: -1};
    end

    for (int i = 0; i < 8; i++) begin
      string nm;
      nm = $sformatf("vec%0d", i);
      build_sched(vecs[i].blk);
      if (vecs[i].use_model) vecs[i].exp = ref_compress(vecs[i].hin);
      run_block(nm, vecs[i].hin, vecs[i].exp, vecs[i].nstall, vecs[i].poke_at, -1);
      hold_check(nm, vecs[i].exp);
    end

    // Abort at round 30, then a clean restart.
    build_sched(ABC_B);
    run_block("abort", IV, ABC_H, 0, -1, 30);
    run_block("restart", IV, ABC_H, 0, -1, -1);
    hold_check("restart", ABC_H);

    // Back-to-back: second block starts in the done cycle of the first.
    b2 = rand512();
    build_sched(b2);
    h2 = ref_compress(ABC_H);
    build_sched(ABC_B);
    run_block("b2b_first", IV, ABC_H, 0, -1, -1);
    build_sched(b2);
    run_block("b2b_second", ABC_H, h2, 2, -1, -1);
    hold_check("b2b_second", h2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
